// File: rtl/mxbiu_prefetch.sv
// Instruction-side MX Bus read master with a DEPTH-entry prefetch queue.
// One outstanding read at a time; redirect flushes the queue and discards in-flight data.
module mxbiu_prefetch #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_STEP  = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       m0_rd_txn_start,
  output logic [ADDR_WIDTH-1:0]      m0_rd_addr,
  input  logic [DATA_WIDTH-1:0]      m0_rd_data,
  input  logic                       m0_rd_ready,
  input  logic                       m0_rd_txn_ack,
  input  logic                       m0_rd_txn_cpl,
  input  logic                       fetch_en,
  input  logic                       redirect,
  input  logic [ADDR_WIDTH-1:0]      redirect_addr,
  output logic                       ins_valid,
  input  logic                       ins_ready,
  output logic [DATA_WIDTH-1:0]      ins_data,
  output logic [ADDR_WIDTH-1:0]      ins_addr,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                  state;
  logic                    txn_start;
  logic [ADDR_WIDTH-1:0]   txn_addr;
  logic [ADDR_WIDTH-1:0]   fp;
  logic                    discard;

  logic [ADDR_WIDTH-1:0]   q_addr [DEPTH];
  logic [DATA_WIDTH-1:0]   q_data [DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;

  logic                    complete;
  logic                    push;
  logic                    pop;
  logic                    can_issue;

  function automatic logic [ADDR_WIDTH-1:0] fp_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(ADDR_STEP);
  endfunction

  assign complete  = ((state == S_REQ) & m0_rd_txn_ack & m0_rd_txn_cpl) |
                     ((state == S_WAIT) & m0_rd_txn_cpl);
  // Redirect wins over everything: no push, no pop, no new issue on that edge.
  assign push      = complete & ~discard & ~redirect;
  assign pop       = (count != '0) & ins_ready & ~redirect;
  assign can_issue = fetch_en & m0_rd_ready & ~redirect & (count < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      txn_start <= 1'b0;
      discard   <= 1'b0;
      fp        <= RESET_ADDR;
    end else begin
      case (state)
        S_IDLE: begin
          if (can_issue) begin
            state     <= S_REQ;
            txn_start <= 1'b1;
          end
        end
        S_REQ: begin
          if (m0_rd_txn_ack) begin
            txn_start <= 1'b0;
            state     <= m0_rd_txn_cpl ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (m0_rd_txn_cpl) state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          txn_start <= 1'b0;
        end
      endcase

      if (redirect) begin
        fp      <= redirect_addr;
        // A request already on the bus must still run to completion; mark its data stale.
        discard <= (state != S_IDLE) & ~complete;
      end else begin
        if (complete) discard <= 1'b0;
        if (push)     fp      <= fp_inc(fp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && can_issue) txn_addr <= fp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= txn_addr;
      q_data[wr_ptr] <= m0_rd_data;
    end
  end

  assign m0_rd_txn_start = txn_start;
  assign m0_rd_addr      = txn_addr;
  assign ins_valid       = (count != '0);
  assign ins_addr        = q_addr[rd_ptr];
  assign ins_data        = q_data[rd_ptr];
  assign q_count         = count;

endmodule

// File: tb/tb_mxbiu_prefetch.sv
// Randomized bench for mxbiu_prefetch: bus responder, transaction-level reference model
// and a scoreboard monitor that checks every popped instruction and the bus-side outputs.
module tb_mxbiu_prefetch;

  localparam int         DEPTH = 4;
  localparam logic [7:0] RST_A = 8'h10;

  logic       clk;
  logic       rst;
  logic       m0_rd_txn_start;
  logic [7:0] m0_rd_addr;
  logic [7:0] m0_rd_data;
  logic       m0_rd_ready;
  logic       m0_rd_txn_ack;
  logic       m0_rd_txn_cpl;
  logic       fetch_en;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic       ins_valid;
  logic       ins_ready;
  logic [7:0] ins_data;
  logic [7:0] ins_addr;
  logic [2:0] q_count;

  mxbiu_prefetch #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(DEPTH), .ADDR_STEP(1), .RESET_ADDR(RST_A)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_rd_txn_start(m0_rd_txn_start), .m0_rd_addr(m0_rd_addr), .m0_rd_data(m0_rd_data),
    .m0_rd_ready(m0_rd_ready), .m0_rd_txn_ack(m0_rd_txn_ack), .m0_rd_txn_cpl(m0_rd_txn_cpl),
    .fetch_en(fetch_en), .redirect(redirect), .redirect_addr(redirect_addr),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data), .ins_addr(ins_addr),
    .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one open read at a time, queue of expected {addr,data} pairs.
  logic [15:0] exp_q[$];
  int          m_cnt = 0;
  bit          m_open, m_acked, m_start, m_disc;
  logic [7:0]  m_fp, m_taddr;
  logic        m_cmp, m_push, m_pop;

  assign m_cmp  = m_open && m0_rd_txn_cpl && (m_acked || m0_rd_txn_ack);
  assign m_push = m_cmp && !m_disc;
  assign m_pop  = ins_ready && (m_cnt != 0);

  always @(posedge clk) begin
    if (rst) begin
      m_open <= 0; m_acked <= 0; m_start <= 0; m_disc <= 0; m_fp <= RST_A; m_cnt <= 0;
      exp_q.delete();
    end else if (redirect) begin
      exp_q.delete();
      m_cnt <= 0;
      m_fp  <= redirect_addr;
      if (m_cmp) begin
        m_open <= 0; m_start <= 0; m_disc <= 0;
      end else if (m_open) begin
        m_disc <= 1;
        if (m0_rd_txn_ack) begin m_acked <= 1; m_start <= 0; end
      end
    end else begin
      if (m_cmp) begin
        m_open <= 0; m_start <= 0;
        if (m_disc) m_disc <= 0;
        else begin
          exp_q.push_back({m_taddr, m0_rd_data});
          m_fp <= m_fp + 8'd1;
        end
      end else if (m_open) begin
        if (m0_rd_txn_ack) begin m_acked <= 1; m_start <= 0; end
      end else if (fetch_en && m0_rd_ready && m_cnt < DEPTH) begin
        m_open <= 1; m_acked <= 0; m_start <= 1; m_taddr <= m_fp;
      end
      m_cnt <= m_cnt - int'(m_pop) + int'(m_push);
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q_count", q_count, m_cnt);
      chk("ins_valid", ins_valid, m_cnt != 0);
      chk("rd_start", m0_rd_txn_start, m_start);
      if (m_open) chk("rd_addr", m0_rd_addr, m_taddr);
      if (!rst && !redirect && ins_ready && m_cnt != 0) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          chk("ins_addr", ins_addr, exp_q[0][15:8]);
          chk("ins_data", ins_data, exp_q[0][7:0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Bus responder and stimulus knobs.
  int         b_st = 0, b_dly = 0;
  logic [7:0] b_addr;
  bit         bus_auto = 1, salt_en = 0;
  int         dly_max = 1, cpl_dly_max = 1, p_same = 50;
  int         p_fetch = 100, p_rdy = 0, p_redir = 0, p_bready = 100;
  bit         found;

  function automatic bit pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic bus_data();
    m0_rd_data = b_addr ^ 8'hFF ^ (salt_en ? 8'($urandom) : 8'h00);
  endtask

  task automatic bus_step();
    m0_rd_txn_ack = 0;
    m0_rd_txn_cpl = 0;
    m0_rd_data    = 8'($urandom);
    if (!bus_auto) return;
    if (b_st == 0 && m0_rd_txn_start) begin
      b_addr = m0_rd_addr; b_dly = $urandom_range(dly_max, 0); b_st = 1;
    end
    if (b_st == 1) begin
      if (b_dly == 0) begin
        m0_rd_txn_ack = 1;
        if (pct(p_same)) begin m0_rd_txn_cpl = 1; bus_data(); b_st = 0; end
        else begin b_st = 2; b_dly = $urandom_range(cpl_dly_max, 0); end
      end else b_dly--;
    end else if (b_st == 2) begin
      if (b_dly == 0) begin m0_rd_txn_cpl = 1; bus_data(); b_st = 0; end
      else b_dly--;
    end
  endtask

  task automatic drive_random();
    fetch_en    = pct(p_fetch);
    ins_ready   = pct(p_rdy);
    m0_rd_ready = pct(p_bready);
    redirect    = pct(p_redir);
    case ($urandom_range(3, 0))
      0:       redirect_addr = 8'hFF;
      1:       redirect_addr = 8'hFE;
      2:       redirect_addr = 8'h80;
      default: redirect_addr = 8'($urandom);
    endcase
    bus_step();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive_random();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; fetch_en = 0; redirect = 0; redirect_addr = 0; ins_ready = 0;
    m0_rd_ready = 0; m0_rd_txn_ack = 0; m0_rd_txn_cpl = 0; m0_rd_data = 0;
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    chk("reset_start", m0_rd_txn_start, 0);
    chk("reset_qcount", q_count, 0);
    chk("reset_valid", ins_valid, 0);
    @(posedge clk); #1;
    rst = 0;

    // Fill with the consumer stalled: four sequential entries, then no further request.
    p_fetch = 100; p_rdy = 0; p_redir = 0; p_bready = 100; salt_en = 0;
    dly_max = 1; cpl_dly_max = 1; p_same = 50;
    run(60);
    @(negedge clk); #1;
    chk("fill_qcount", q_count, 4);
    chk("fill_head_addr", ins_addr, 8'h10);
    chk("fill_head_data", ins_data, 8'hEF);
    chk("fill_no_fifth", m0_rd_txn_start, 0);

    // Streaming with single-cycle bus and an always-ready consumer.
    p_rdy = 100; dly_max = 0; p_same = 100;
    run(60);

    // Randomized traffic with redirects, stalls and varied bus latency.
    salt_en = 1; dly_max = 3; cpl_dly_max = 3; p_same = 40;
    p_fetch = 80; p_rdy = 60; p_redir = 8; p_bready = 80;
    run(3000);
    p_redir = 35;
    run(500);
    p_redir = 3; p_rdy = 25;
    run(800);

    // Reset while a read is waiting for completion, then a stray completion.
    p_redir = 0; p_fetch = 100; p_rdy = 0; p_same = 0; cpl_dly_max = 6; p_bready = 100;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (b_st == 2 && b_dly >= 1) found = 1;
      else drive_random();
    end
    if (!found) chk("rst_wait_timeout", 0, 1);
    rst = 1; redirect = 0; fetch_en = 0; m0_rd_txn_ack = 0; m0_rd_txn_cpl = 0; b_st = 0;
    @(posedge clk); #1;
    rst = 0; bus_auto = 0; bus_step();
    @(negedge clk); #1;
    chk("midrst_start", m0_rd_txn_start, 0);
    chk("midrst_qcount", q_count, 0);
    @(posedge clk); #1;
    m0_rd_txn_cpl = 1; m0_rd_data = 8'h5A;
    @(posedge clk); #1;
    m0_rd_txn_cpl = 0;
    @(negedge clk); #1;
    chk("stray_cpl_qcount", q_count, 0);
    chk("stray_cpl_valid", ins_valid, 0);

    bus_auto = 1; b_st = 0; p_fetch = 100; p_bready = 100; p_rdy = 50; p_same = 50; cpl_dly_max = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      drive_random();
      @(negedge clk); #1;
      if (m0_rd_txn_start) found = 1;
    end
    if (!found) chk("post_rst_fetch_timeout", 0, 1);
    else chk("post_rst_addr", m0_rd_addr, RST_A);

    p_redir = 8; p_fetch = 85; p_bready = 80; dly_max = 3; cpl_dly_max = 3;
    run(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
